// File: rtl/updown_pkg.sv
// Shared encodings and constants for the up/down counter controller.
package updown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_UP   = 2'b01,
    ST_DOWN = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

  // Count values at which the controller reverses so the counter never wraps.
  localparam logic [3:0] TURN_HI = 4'hE;
  localparam logic [3:0] TURN_LO = 4'h1;

  localparam int DB_CYCLES_DEF = 4;

endpackage

// File: rtl/updown_ctrl_btn_debounce.sv
// One button channel: 2-flop synchronizer, debounce counter and a
// registered one-cycle pulse on each debounced rising edge.
module btn_debounce
  import updown_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  logic       sync1_q, sync2_q;
  logic       level_q, level_prev_q;
  logic       press_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= btn_i;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
      // Any sample agreeing with the accepted level restarts the run.
      if (sync2_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == 8'(DB_CYCLES - 1)) begin
        level_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/updown_ctrl.sv
// Button-driven controller for an external 4-bit up/down counter with
// stop/hold handling and optional auto-reverse at the count limits.
module updown_ctrl
  import updown_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF,
  parameter bit BOUNCE    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_stop,
  input  logic [3:0] count,
  output logic       enable,
  output logic       up_down,
  output logic [1:0] state
);

  logic   up_p, down_p, stop_p;
  state_e state_q, state_d;
  logic   dir_q, dir_d;
  logic   enable_q;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .reset(reset), .btn_i(btn_up), .press_o(up_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_down (
    .clk(clk), .reset(reset), .btn_i(btn_down), .press_o(down_p)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_stop (
    .clk(clk), .reset(reset), .btn_i(btn_stop), .press_o(stop_p)
  );

  always_comb begin
    state_d = state_q;
    if (stop_p) begin
      unique case (state_q)
        ST_UP, ST_DOWN: state_d = ST_HOLD;
        default:        state_d = ST_IDLE;
      endcase
    end else if (up_p && !down_p) begin
      state_d = ST_UP;
    end else if (down_p && !up_p) begin
      state_d = ST_DOWN;
    end else if (BOUNCE) begin
      // Reverse one step early so the counter peaks at F and bottoms at 0.
      if (state_q == ST_UP && count == TURN_HI) begin
        state_d = ST_DOWN;
      end else if (state_q == ST_DOWN && count == TURN_LO) begin
        state_d = ST_UP;
      end
    end

    unique case (state_d)
      ST_DOWN: dir_d = 1'b0;
      ST_HOLD: dir_d = dir_q;
      default: dir_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dir_q    <= 1'b1;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      enable_q <= (state_d == ST_UP) || (state_d == ST_DOWN);
    end
  end

  assign state   = state_q;
  assign enable  = enable_q;
  assign up_down = dir_q;

endmodule

// File: tb/tb_updown_ctrl.sv
// Bench for updown_ctrl: directed scenarios plus randomized button traffic
// checked against a sample-history reference model.
module tb_updown_ctrl;

  localparam int DB   = 4;
  localparam bit BNC  = 1'b1;
  localparam int MAXC = 8192;
  localparam logic [1:0] S_IDLE = 2'd0, S_UP = 2'd1, S_DOWN = 2'd2, S_HOLD = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_stop = 1'b0;
  logic [3:0] count = 4'd0;
  logic       enable, up_down;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  updown_ctrl #(.DB_CYCLES(DB), .BOUNCE(BNC)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down),
    .btn_stop(btn_stop), .count(count), .enable(enable),
    .up_down(up_down), .state(state)
  );

  // Reference model: raw samples per edge, accepted levels per edge, FSM.
  bit         raw_h [3][MAXC];
  bit         lv_h  [3][MAXC];
  bit         rst_h [MAXC];
  int         n_edge = 0;
  logic [1:0] m_st = S_IDLE;
  bit         m_dir = 1'b1;
  logic [3:0] env_cnt = 4'd0;

  function automatic bit raw_at(int b, int i);
    if (i < 0) return 1'b0;
    return raw_h[b][i];
  endfunction

  function automatic bit lv_at(int b, int i);
    if (i < 0) return 1'b0;
    return lv_h[b][i];
  endfunction

  function automatic bit rst_at(int i);
    if (i < 0) return 1'b0;
    return rst_h[i];
  endfunction

  function automatic bit m_en();
    return (m_st == S_UP) || (m_st == S_DOWN);
  endfunction

  task automatic tick(input bit r, input bit u, input bit d, input bit s);
    bit   in_b [3];
    bit   pr [3];
    bit   flip, prev_lv;
    logic e_old, ud_old;
    reset = r; btn_up = u; btn_down = d; btn_stop = s; count = env_cnt;
    e_old = enable; ud_old = up_down;
    @(posedge clk);
    #1;
    in_b = '{u, d, s};
    rst_h[n_edge] = r;
    for (int b = 0; b < 3; b++) begin
      raw_h[b][n_edge] = r ? 1'b0 : in_b[b];
      if (r && n_edge > 0) raw_h[b][n_edge-1] = 1'b0;
      prev_lv = lv_at(b, n_edge - 1);
      if (r) begin
        lv_h[b][n_edge] = 1'b0;
      end else begin
        flip = 1'b1;
        for (int j = 2; j <= DB + 1; j++)
          if (raw_at(b, n_edge - j) == prev_lv) flip = 1'b0;
        lv_h[b][n_edge] = flip ? !prev_lv : prev_lv;
      end
      pr[b] = !rst_at(n_edge - 1) && lv_at(b, n_edge - 2) && !lv_at(b, n_edge - 3);
    end
    if (r) begin
      m_st = S_IDLE; m_dir = 1'b1;
    end else begin
      if (pr[2]) m_st = (m_st == S_UP || m_st == S_DOWN) ? S_HOLD : S_IDLE;
      else if (pr[0] && !pr[1]) m_st = S_UP;
      else if (pr[1] && !pr[0]) m_st = S_DOWN;
      else if (BNC && m_st == S_UP && count == 4'hE) m_st = S_DOWN;
      else if (BNC && m_st == S_DOWN && count == 4'h1) m_st = S_UP;
      if (m_st == S_DOWN) m_dir = 1'b0;
      else if (m_st != S_HOLD) m_dir = 1'b1;
    end
    // Downstream counter follows the DUT's enable/direction before the edge.
    if (e_old === 1'b1) env_cnt = (ud_old === 1'b1) ? env_cnt + 4'd1 : env_cnt - 4'd1;
    n_edge++;
    if (n_edge >= MAXC) begin
      $display("FAIL model_history_overflow edges=%0d limit=%0d", n_edge, MAXC);
      $fatal(1, "history overflow");
    end
  endtask

  task automatic hold(input bit r, input bit u, input bit d, input bit s, input int n);
    for (int i = 0; i < n; i++) tick(r, u, d, s);
  endtask

  task automatic test_reset();
    hold(1, 1, 1, 1, 3);
    n_cmp++;
    if (state !== S_IDLE || enable !== 1'b0 || up_down !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state got st=%b en=%b ud=%b want st=00 en=0 ud=1", state, enable, up_down);
    end
  endtask

  task automatic test_latency();
    hold(1, 0, 0, 0, 2);
    env_cnt = 4'd0;
    for (int i = 1; i <= DB + 4; i++) begin
      tick(0, 1, 0, 0);
      n_cmp++;
      if (i < DB + 4) begin
        if (state !== S_IDLE || enable !== 1'b0) begin
          n_bad++;
          $display("FAIL latency_early edge=E0+%0d got st=%b en=%b want st=00 en=0", i - 1, state, enable);
        end
      end else if (state !== S_UP || enable !== 1'b1 || up_down !== 1'b1) begin
        n_bad++;
        $display("FAIL latency_up got st=%b en=%b ud=%b want st=01 en=1 ud=1", state, enable, up_down);
      end
    end
  endtask

  task automatic test_glitch();
    hold(1, 0, 0, 0, 2);
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, (i % 2) == 0, 0);
      n_cmp++;
      if (state !== S_IDLE) begin
        n_bad++;
        $display("FAIL glitch_ignored cyc=%0d got st=%b want st=00", i, state);
      end
    end
    for (int i = 1; i <= DB + 4; i++) begin
      tick(0, 0, 1, 0);
      if (i >= DB + 3) begin
        n_cmp++;
        if (i == DB + 3 && state !== S_IDLE) begin
          n_bad++;
          $display("FAIL glitch_then_hold_early got st=%b want st=00", state);
        end else if (i == DB + 4 && (state !== S_DOWN || enable !== 1'b1 || up_down !== 1'b0)) begin
          n_bad++;
          $display("FAIL glitch_then_hold got st=%b en=%b ud=%b want st=10 en=1 ud=0", state, enable, up_down);
        end
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] prev;
    bit         saw_f;
    hold(1, 0, 0, 0, 2);
    env_cnt = 4'd0;
    hold(0, 1, 0, 0, DB + 4);
    n_cmp++;
    if (state !== S_UP || env_cnt !== 4'd0) begin
      n_bad++;
      $display("FAIL bounce_start got st=%b cnt=%h want st=01 cnt=0", state, env_cnt);
    end
    saw_f = 1'b0;
    for (int i = 0; i < 40; i++) begin
      prev = env_cnt;
      tick(0, 0, 0, 0);
      if (i < 15) begin
        n_cmp++;
        if (env_cnt !== 4'(i + 1)) begin
          n_bad++;
          $display("FAIL bounce_ramp step=%0d got cnt=%h want cnt=%h", i, env_cnt, 4'(i + 1));
        end
      end
      if (prev == 4'hF) begin
        n_cmp++;
        if (env_cnt !== 4'hE) begin
          n_bad++;
          $display("FAIL bounce_no_wrap_F got next=%h want E", env_cnt);
        end
      end
      if (prev == 4'hE && env_cnt == 4'hF && !saw_f) begin
        saw_f = 1'b1;
        n_cmp++;
        if (up_down !== 1'b0 || state !== S_DOWN) begin
          n_bad++;
          $display("FAIL bounce_turn_hi got st=%b ud=%b want st=10 ud=0", state, up_down);
        end
      end
    end
    n_cmp++;
    if (!saw_f) begin
      n_bad++;
      $display("FAIL bounce_reach_F got reached=0 want reached=1");
    end
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    hold(1, 0, 0, 0, 2);
    env_cnt = 4'd0;
    hold(0, 0, 1, 0, DB + 4);
    tick(0, 0, 0, 0);
    n_cmp++;
    if (state !== S_DOWN || env_cnt !== 4'hF) begin
      n_bad++;
      $display("FAIL wrap_once got st=%b cnt=%h want st=10 cnt=F", state, env_cnt);
    end
    for (int i = 0; i < 24; i++) begin
      prev = env_cnt;
      tick(0, 0, 0, 0);
      if (prev == 4'h1 && env_cnt == 4'h0) begin
        n_cmp++;
        if (state !== S_UP || up_down !== 1'b1) begin
          n_bad++;
          $display("FAIL wrap_turn_lo got st=%b ud=%b want st=01 ud=1", state, up_down);
        end
      end
      if (prev == 4'h0) begin
        n_cmp++;
        if (env_cnt !== 4'h1) begin
          n_bad++;
          $display("FAIL wrap_no_second got next=%h want 1", env_cnt);
        end
      end
    end
  endtask

  task automatic test_stop_hold();
    logic [3:0] frozen;
    hold(1, 0, 0, 0, 2);
    env_cnt = 4'd0;
    hold(0, 1, 0, 0, DB + 4);
    hold(0, 0, 0, 0, 2);
    n_cmp++;
    if (state !== S_UP || enable !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_pre_up got st=%b en=%b want st=01 en=1", state, enable);
    end
    hold(0, 0, 0, 1, DB + 4);
    n_cmp++;
    if (state !== S_HOLD || enable !== 1'b0 || up_down !== 1'b1) begin
      n_bad++;
      $display("FAIL stop_to_hold got st=%b en=%b ud=%b want st=11 en=0 ud=1", state, enable, up_down);
    end
    tick(0, 0, 0, 0);
    frozen = env_cnt;
    hold(0, 0, 0, 0, 5);
    n_cmp++;
    if (state !== S_HOLD || env_cnt !== frozen) begin
      n_bad++;
      $display("FAIL hold_frozen got st=%b cnt=%h want st=11 cnt=%h", state, env_cnt, frozen);
    end
    hold(0, 1, 1, 0, DB + 4);
    hold(0, 0, 0, 0, 3);
    n_cmp++;
    if (state !== S_HOLD || enable !== 1'b0) begin
      n_bad++;
      $display("FAIL up_down_together got st=%b en=%b want st=11 en=0", state, enable);
    end
    hold(0, 0, 0, 1, DB + 4);
    n_cmp++;
    if (state !== S_IDLE || enable !== 1'b0 || up_down !== 1'b1) begin
      n_bad++;
      $display("FAIL hold_to_idle got st=%b en=%b ud=%b want st=00 en=0 ud=1", state, enable, up_down);
    end
    hold(0, 0, 0, 0, 3);
  endtask

  task automatic test_reset_mid();
    int guard;
    hold(1, 0, 0, 0, 2);
    env_cnt = 4'd8;
    hold(0, 0, 1, 0, DB + 4);
    hold(0, 0, 0, 0, 1);
    guard = 0;
    while (env_cnt != 4'd5 && guard < 12) begin
      tick(0, 0, 0, 0);
      guard++;
    end
    n_cmp++;
    if (state !== S_DOWN || env_cnt !== 4'd5) begin
      n_bad++;
      $display("FAIL reset_mid_setup got st=%b cnt=%h want st=10 cnt=5", state, env_cnt);
    end
    tick(1, 1, 0, 0);
    n_cmp++;
    if (state !== S_IDLE || enable !== 1'b0 || up_down !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid got st=%b en=%b ud=%b want st=00 en=0 ud=1", state, enable, up_down);
    end
    for (int i = 1; i <= DB + 4; i++) begin
      tick(0, 1, 0, 0);
      if (i >= DB + 3) begin
        n_cmp++;
        if (i == DB + 3 && state !== S_IDLE) begin
          n_bad++;
          $display("FAIL held_through_reset_early got st=%b want st=00", state);
        end else if (i == DB + 4 && state !== S_UP) begin
          n_bad++;
          $display("FAIL held_through_reset got st=%b want st=01", state);
        end
      end
    end
    hold(0, 0, 0, 0, 2);
  endtask

  task automatic test_random();
    bit r, u, d, s, glitch;
    int len;
    logic [2:0] pat;
    hold(1, 0, 0, 0, 2);
    for (int seg = 0; seg < 220; seg++) begin
      r      = ($urandom_range(0, 29) == 0);
      pat    = 3'($urandom_range(0, 7));
      len    = $urandom_range(1, 2 * DB + 4);
      glitch = ($urandom_range(0, 2) == 0);
      for (int t = 0; t < len; t++) begin
        u = pat[0]; d = pat[1]; s = pat[2];
        if (glitch && (t % 2) == 1) begin u = 1'b0; d = 1'b0; s = 1'b0; end
        tick(r && t == 0, u, d, s);
        n_cmp++;
        if (state !== m_st || enable !== m_en() || up_down !== m_dir) begin
          n_bad++;
          $display("FAIL random_cycle edge=%0d got st=%b en=%b ud=%b want st=%b en=%b ud=%b",
                   n_edge, state, enable, up_down, m_st, m_en(), m_dir);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_glitch();
    test_bounce();
    test_wrap();
    test_stop_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
